hamming_scrub_ctrl: RTL and testbench
=====================================

HAMMING_SCRUB_CTRL -- requirements
Module: hamming_scrub_ctrl

Interface
REQ-001 SHALL have parameter SCRUB_INTERVAL, default 16: cycles between scrub slots while scrub_en=1; legal range 4..255.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  host request present.
REQ-005 SHALL have port req_ready  output  1  host request accepted when req_valid=1 and req_ready=1 at an edge.
REQ-006 SHALL have port req_we  input  1  1=write, 0=read.
REQ-007 SHALL have port req_addr  input  3  entry index 0..7.
REQ-008 SHALL have port req_wdata  input  4  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle read-response strobe; no backpressure.
REQ-010 SHALL have port rsp_rdata  output  4  corrected read data.
REQ-011 SHALL have port rsp_err  output  2  00 clean, 01 data bit corrected, 10 parity bit corrected.
REQ-012 SHALL have port scrub_en  input  1  enables background scrubbing.
REQ-013 SHALL have port inj_valid  input  1  error-injection strobe.
REQ-014 SHALL have port inj_addr  input  3  entry index to corrupt.
REQ-015 SHALL have port inj_mask  input  7  XOR mask applied to the stored codeword.
REQ-016 SHALL have port err_count  output  8  saturating count of corrected events.

Function
REQ-017 SHALL store 8 entries of 7-bit codeword c[6:0]; c[6:4]=d[3:1], c[2]=d[0], c[0]=c6^c4^c2, c[1]=c6^c5^c2, c[3]=c6^c5^c4.
REQ-018 SHALL decode with syndrome s={c3^c6^c5^c4, c1^c6^c5^c2, c0^c6^c4^c2}; s!=0 means bit (s-1) is flipped; s in {3,5,6,7} gives rsp_err=01; s in {1,2,4} gives rsp_err=10.
REQ-019 SHALL use an FSM with states IDLE, HOST_RD and SCRUB; req_ready=1 only in IDLE with no scrub pending.
REQ-020 SHALL handle a write accepted at edge N by storing encode(req_wdata) at edge N; state stays IDLE; no response.
REQ-021 SHALL handle a read accepted at edge N by moving to HOST_RD and latching req_addr.
REQ-022 SHALL, at edge N+1, decode the latched entry, register rsp_rdata and rsp_err, drive rsp_valid=1 for the cycle after edge N+1 (latency 2), and return to IDLE.
REQ-023 SHALL, on a host read with s!=0, write the corrected codeword back at edge N+1.
REQ-024 SHALL count cycles with a scrub counter while scrub_en=1 and hold the counter while scrub_en=0; at count SCRUB_INTERVAL-1 it SHALL set scrub_pending and wrap to 0.
REQ-025 SHALL, in IDLE with scrub_pending=1, move to SCRUB; scrub takes priority over a simultaneous host request.
REQ-026 SHALL, at the edge leaving SCRUB, decode mem[scrub_ptr], write back the corrected codeword if s!=0, clear scrub_pending, increment scrub_ptr (7 wraps to 0) and return to IDLE; no rsp_valid.
REQ-027 SHALL increment err_count by 1 on each host-read or scrub decode with s!=0, saturating at 255.
REQ-028 SHALL, when inj_valid=1 at an edge, XOR inj_mask into mem[inj_addr] in any state; when the same entry is written or written back at that edge, the mask SHALL apply on top of the new value.
REQ-029 SHALL make a scrub_pending set while pending already set a no-op; a missed slot is not queued.
REQ-030 SHALL treat double-bit errors as silently miscorrected; no detection is required.

Reset
REQ-031 SHALL, with rst_n=0 at an edge: FSM to IDLE, all entries to 0x00, scrub counter, scrub_ptr, scrub_pending and err_count to 0, and rsp_valid, rsp_rdata, rsp_err to 0.
REQ-032 SHALL drive req_ready=1 in the first cycle after reset release.
REQ-033 SHALL abort a read in HOST_RD when reset is taken there: no rsp_valid, no write-back.

Verification
REQ-034 SHALL cover: write 0xB to addr 3, then read addr 3 -> stored codeword 0x55; rsp_valid 2 cycles after accept; rdata 0xB, err 00, err_count 0.
REQ-035 SHALL cover: inject mask 0x10 at addr 3, then read -> rdata 0xB, err 01, err_count 1; a re-read gives err 00.
REQ-036 SHALL cover: inject mask 0x08 at addr 3, then read -> rdata 0xB, err 10, err_count increments.
REQ-037 SHALL cover: scrub_en=1, inject one single-bit error in each of the 8 entries, wait 8*SCRUB_INTERVAL+8 cycles -> all reads err 00, err_count 8, and req_ready low in each scrub slot.
REQ-038 SHALL cover: inject and read 260 times -> err_count holds at 255.
REQ-039 SHALL cover: rst_n=0 during HOST_RD -> no rsp_valid, err_count 0, and reads of all entries return 0x0 with err 00.

Source files
------------

// File: rtl/hamming_scrub_ctrl.sv
// ============================================================================
// hamming_scrub_ctrl
// ----------------------------------------------------------------------------
// Eight-entry store of Hamming(7,4) codewords with host read/write access,
// single-bit correction on every read, write-back of corrected codewords,
// periodic background scrubbing and an error-injection port.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   req_valid  : host request present
//   req_ready  : high in IDLE when no scrub is pending
//   req_we     : 1 = write, 0 = read
//   req_addr   : entry index 0..7
//   req_wdata  : 4-bit write data
//   rsp_valid  : one-cycle read-response strobe (latency 2 from accept)
//   rsp_rdata  : corrected read data
//   rsp_err    : 00 clean, 01 data bit corrected, 10 parity bit corrected
//   scrub_en   : enables background scrubbing
//   inj_valid  : error-injection strobe
//   inj_addr   : entry index to corrupt
//   inj_mask   : XOR mask applied to the stored codeword
//   err_count  : saturating count of corrected events
// ============================================================================
module hamming_scrub_ctrl #(
   parameter int unsigned SCRUB_INTERVAL = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [2:0] req_addr,
   input  logic [3:0] req_wdata,
   output logic       rsp_valid,
   output logic [3:0] rsp_rdata,
   output logic [1:0] rsp_err,
   input  logic       scrub_en,
   input  logic       inj_valid,
   input  logic [2:0] inj_addr,
   input  logic [6:0] inj_mask,
   output logic [7:0] err_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOST_RD = 2'd1,
      SCRUB   = 2'd2
   } state_e;

   localparam logic [7:0] CNT_LAST = 8'(SCRUB_INTERVAL - 1);

   // Codeword layout: c[6:4]=d[3:1], c[2]=d[0], parity at c[0], c[1], c[3].
   function automatic logic [6:0] encode(input logic [3:0] d);
      logic [6:0] c;
      c    = 7'd0;
      c[6] = d[3];
      c[5] = d[2];
      c[4] = d[1];
      c[2] = d[0];
      c[0] = c[6] ^ c[4] ^ c[2];
      c[1] = c[6] ^ c[5] ^ c[2];
      c[3] = c[6] ^ c[5] ^ c[4];
      return c;
   endfunction

   function automatic logic [2:0] syndrome(input logic [6:0] c);
      return {c[3] ^ c[6] ^ c[5] ^ c[4],
              c[1] ^ c[6] ^ c[5] ^ c[2],
              c[0] ^ c[6] ^ c[4] ^ c[2]};
   endfunction

   // A non-zero syndrome names the flipped bit as (s-1).
   function automatic logic [6:0] fix_cw(input logic [6:0] c, input logic [2:0] s);
      logic [6:0] flip;
      flip = 7'd0;
      if (s != 3'd0) begin
         flip[s - 3'd1] = 1'b1;
      end else begin
         flip = 7'd0;
      end
      return c ^ flip;
   endfunction

   function automatic logic [3:0] cw_data(input logic [6:0] c);
      return {c[6], c[5], c[4], c[2]};
   endfunction

   // Syndromes 3,5,6,7 point at data bits, 1,2,4 at parity bits.
   function automatic logic [1:0] err_code(input logic [2:0] s);
      logic [1:0] e;
      case (s)
         3'd0:                e = 2'b00;
         3'd1, 3'd2, 3'd4:    e = 2'b10;
         default:             e = 2'b01;
      endcase
      return e;
   endfunction

   state_e     state_q, state_d;
   logic [2:0] rd_addr_q, rd_addr_d;
   logic [2:0] scrub_ptr_q, scrub_ptr_d;
   logic [7:0] scrub_cnt_q, scrub_cnt_d;
   logic       pending_q, pending_d;
   logic [7:0] err_count_q, err_count_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [3:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0] rsp_err_q, rsp_err_d;
   logic [6:0] mem_q [8];
   logic [6:0] mem_d [8];

   logic [2:0] dec_addr_s;
   logic [6:0] dec_cw_s;
   logic [2:0] dec_syn_s;
   logic [6:0] dec_fix_s;
   logic       wr_en_s;
   logic [2:0] wr_addr_s;
   logic [6:0] wr_cw_s;
   logic       pend_set_s;
   logic       pend_clr_s;
   logic       cnt_inc_s;

   assign req_ready = (state_q == IDLE) && !pending_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign err_count = err_count_q;

   // Shared decoder: scrub reads the scrub pointer, host reads the latched address.
   always_comb begin
      if (state_q == SCRUB) begin
         dec_addr_s = scrub_ptr_q;
      end else begin
         dec_addr_s = rd_addr_q;
      end
      dec_cw_s  = mem_q[dec_addr_s];
      dec_syn_s = syndrome(dec_cw_s);
      dec_fix_s = fix_cw(dec_cw_s, dec_syn_s);
   end

   // FSM next state, host/scrub write port and response fields.
   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      scrub_ptr_d = scrub_ptr_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      wr_en_s     = 1'b0;
      wr_addr_s   = req_addr;
      wr_cw_s     = encode(req_wdata);
      pend_clr_s  = 1'b0;
      cnt_inc_s   = 1'b0;
      case (state_q)
         IDLE: begin
            // A pending scrub wins over a simultaneous host request.
            if (pending_q) begin
               state_d = SCRUB;
            end else if (req_valid) begin
               if (req_we) begin
                  wr_en_s = 1'b1;
               end else begin
                  state_d   = HOST_RD;
                  rd_addr_d = req_addr;
               end
            end else begin
               state_d = IDLE;
            end
         end
         HOST_RD: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = cw_data(dec_fix_s);
            rsp_err_d   = err_code(dec_syn_s);
            wr_addr_s   = rd_addr_q;
            wr_cw_s     = dec_fix_s;
            wr_en_s     = (dec_syn_s != 3'd0);
            cnt_inc_s   = (dec_syn_s != 3'd0);
         end
         SCRUB: begin
            state_d     = IDLE;
            pend_clr_s  = 1'b1;
            scrub_ptr_d = scrub_ptr_q + 3'd1;
            wr_addr_s   = scrub_ptr_q;
            wr_cw_s     = dec_fix_s;
            wr_en_s     = (dec_syn_s != 3'd0);
            cnt_inc_s   = (dec_syn_s != 3'd0);
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Scrub interval counter, pending flag (a new slot wins over a clear) and error counter.
   always_comb begin
      scrub_cnt_d = scrub_cnt_q;
      pend_set_s  = 1'b0;
      if (scrub_en) begin
         if (scrub_cnt_q == CNT_LAST) begin
            scrub_cnt_d = 8'd0;
            pend_set_s  = 1'b1;
         end else begin
            scrub_cnt_d = scrub_cnt_q + 8'd1;
         end
      end else begin
         scrub_cnt_d = scrub_cnt_q;
      end

      if (pend_set_s) begin
         pending_d = 1'b1;
      end else if (pend_clr_s) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end

      if (cnt_inc_s && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end else begin
         err_count_d = err_count_q;
      end
   end

   // Memory next state: write or write-back first, injection mask on top.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         mem_d[i] = mem_q[i];
         if (wr_en_s && (wr_addr_s == 3'(i))) begin
            mem_d[i] = wr_cw_s;
         end else begin
            mem_d[i] = mem_q[i];
         end
         if (inj_valid && (inj_addr == 3'(i))) begin
            mem_d[i] = mem_d[i] ^ inj_mask;
         end else begin
            mem_d[i] = mem_d[i];
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rd_addr_q   <= 3'd0;
         scrub_ptr_q <= 3'd0;
         scrub_cnt_q <= 8'd0;
         pending_q   <= 1'b0;
         err_count_q <= 8'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 4'd0;
         rsp_err_q   <= 2'd0;
         for (int i = 0; i < 8; i++) begin
            mem_q[i] <= 7'd0;
         end
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         scrub_ptr_q <= scrub_ptr_d;
         scrub_cnt_q <= scrub_cnt_d;
         pending_q   <= pending_d;
         err_count_q <= err_count_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         for (int i = 0; i < 8; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// ============================================================================
// tb_hamming_scrub_ctrl
// Self-checking bench: a transaction-level reference model (nearest-codeword
// decoding by exhaustive search) is stepped on every rising edge and every
// DUT output is compared against it on the following falling edge. Directed
// sequences add hand-computed literal expectations.
// ============================================================================
module tb_hamming_scrub_ctrl;

   localparam int SI = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_we;
   logic [2:0] req_addr;
   logic [3:0] req_wdata;
   logic       rsp_valid;
   logic [3:0] rsp_rdata;
   logic [1:0] rsp_err;
   logic       scrub_en;
   logic       inj_valid;
   logic [2:0] inj_addr;
   logic [6:0] inj_mask;
   logic [7:0] err_count;

   always #5 clk = ~clk;

   hamming_scrub_ctrl #(.SCRUB_INTERVAL(SI)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .scrub_en  (scrub_en),
      .inj_valid (inj_valid),
      .inj_addr  (inj_addr),
      .inj_mask  (inj_mask),
      .err_count (err_count)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;
   int slot_cnt = 0;

   // Reference model state (busy: 0 idle, 1 host read in flight, 2 scrub slot)
   logic [6:0] m_mem [8];
   int         m_busy = 0;
   int         m_rd   = 0;
   int         m_pend = 0;
   int         m_cnt  = 0;
   int         m_ptr  = 0;
   int         m_errs = 0;
   logic       m_rv   = 1'b0;
   logic [3:0] m_data = 4'd0;
   logic [1:0] m_err  = 2'd0;

   function automatic logic [6:0] m_enc(input logic [3:0] d);
      logic [6:0] c;
      c    = 7'd0;
      c[6] = d[3];
      c[5] = d[2];
      c[4] = d[1];
      c[2] = d[0];
      c[0] = c[6] ^ c[4] ^ c[2];
      c[1] = c[6] ^ c[5] ^ c[2];
      c[3] = c[6] ^ c[5] ^ c[4];
      return c;
   endfunction

   // Nearest valid codeword by exhaustive search over all 16 data values.
   task automatic m_decode(input logic [6:0] cw, output logic [6:0] fx,
                           output logic [3:0] dv, output logic [1:0] ev);
      logic [6:0] diff;
      logic [6:0] e;
      fx = 7'd0;
      dv = 4'd0;
      for (int v = 0; v < 16; v++) begin
         e = m_enc(4'(v));
         if ($countones(e ^ cw) <= 1) begin
            fx = e;
            dv = 4'(v);
         end
      end
      diff = fx ^ cw;
      if (diff == 7'd0)               ev = 2'b00;
      else if ((diff & 7'h74) != 7'd0) ev = 2'b01;
      else                            ev = 2'b10;
   endtask

   function automatic logic m_ready();
      return (m_busy == 0) && (m_pend == 0);
   endfunction

   function automatic int m_sat();
      return (m_errs > 255) ? 255 : m_errs;
   endfunction

   task automatic m_step();
      logic [6:0] fx;
      logic [3:0] dv;
      logic [1:0] ev;
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_mem[i] = 7'd0;
         m_busy = 0; m_rd = 0; m_pend = 0; m_cnt = 0; m_ptr = 0; m_errs = 0;
         m_rv = 1'b0; m_data = 4'd0; m_err = 2'd0;
      end else begin
         m_rv = 1'b0;
         if (m_busy == 1) begin
            m_decode(m_mem[m_rd], fx, dv, ev);
            m_rv = 1'b1; m_data = dv; m_err = ev;
            if (ev != 2'b00) begin m_mem[m_rd] = fx; m_errs++; end
            m_busy = 0;
         end else if (m_busy == 2) begin
            m_decode(m_mem[m_ptr], fx, dv, ev);
            if (ev != 2'b00) begin m_mem[m_ptr] = fx; m_errs++; end
            m_ptr = (m_ptr + 1) % 8;
            m_pend = 0;
            m_busy = 0;
         end else if (m_pend != 0) begin
            m_busy = 2;
         end else if (req_valid) begin
            if (req_we) m_mem[req_addr] = m_enc(req_wdata);
            else begin m_busy = 1; m_rd = int'(req_addr); end
         end
         if (inj_valid) m_mem[inj_addr] = m_mem[inj_addr] ^ inj_mask;
         if (scrub_en) begin
            if (m_cnt == SI - 1) begin m_cnt = 0; m_pend = 1; end
            else m_cnt++;
         end
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare_cycle();
      check("req_ready", 32'(req_ready), 32'(m_ready()));
      check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      if (m_rv) begin
         check("rsp_rdata", 32'(rsp_rdata), 32'(m_data));
         check("rsp_err", 32'(rsp_err), 32'(m_err));
      end
      check("err_count", 32'(err_count), 32'(m_sat()));
      if (m_busy == 2) begin
         slot_cnt++;
         check("ready_in_scrub", 32'(req_ready), 32'd0);
      end
   endtask

   // One clock: compare on the falling edge, step the model on the rising edge.
   task automatic tick();
      @(negedge clk);
      if (chk_en) compare_cycle();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!m_ready() && n < 64) begin
         tick();
         n++;
      end
      check("wait_ready", 32'(n < 64), 32'd1);
   endtask

   task automatic do_write(input logic [2:0] a, input logic [3:0] d);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
      wait_ready();
      tick();
      req_valid = 1'b0; req_we = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] a, input logic [3:0] ed, input logic [1:0] ee);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      wait_ready();
      tick();
      req_valid = 1'b0;
      check("rd_not_early", 32'(rsp_valid), 32'd0);
      tick();
      check("rd_valid_lat2", 32'(rsp_valid), 32'd1);
      check("rd_data", 32'(rsp_rdata), 32'(ed));
      check("rd_err", 32'(rsp_err), 32'(ee));
   endtask

   task automatic do_inject(input logic [2:0] a, input logic [6:0] m);
      inj_valid = 1'b1; inj_addr = a; inj_mask = m;
      tick();
      inj_valid = 1'b0; inj_mask = 7'd0;
   endtask

   initial begin
      logic [1:0] ee;
      int b;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 3'd0; req_wdata = 4'd0;
      scrub_en = 1'b0; inj_valid = 1'b0; inj_addr = 3'd0; inj_mask = 7'd0;
      for (int i = 0; i < 8; i++) m_mem[i] = 7'd0;

      tick();
      chk_en = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);

      // Clean write/read of 0xB at entry 3
      do_write(3'd3, 4'hB);
      check("model_enc_0x55", 32'(m_mem[3]), 32'h55);
      do_read(3'd3, 4'hB, 2'b00);
      check("clean_err_count", 32'(err_count), 32'd0);

      // Data-bit error, then re-read is clean after write-back
      do_inject(3'd3, 7'h10);
      do_read(3'd3, 4'hB, 2'b01);
      check("data_fix_count", 32'(err_count), 32'd1);
      do_read(3'd3, 4'hB, 2'b00);

      // Parity-bit error
      do_inject(3'd3, 7'h08);
      do_read(3'd3, 4'hB, 2'b10);
      check("par_fix_count", 32'(err_count), 32'd2);

      // Background scrub repairs one error in every entry
      do_reset();
      for (int i = 0; i < 8; i++) do_write(3'(i), 4'((i * 3 + 1) & 15));
      for (int i = 0; i < 8; i++) do_inject(3'(i), 7'(1 << (i % 7)));
      scrub_en = 1'b1;
      slot_cnt = 0;
      repeat (8 * SI + 8) tick();
      scrub_en = 1'b0;
      check("scrub_slots", 32'(slot_cnt), 32'd8);
      check("scrub_err_count", 32'(err_count), 32'd8);
      for (int i = 0; i < 8; i++) do_read(3'(i), 4'((i * 3 + 1) & 15), 2'b00);
      check("scrub_err_count_after", 32'(err_count), 32'd8);

      // Reset taken in HOST_RD aborts the read
      do_write(3'd2, 4'h6);
      do_inject(3'd2, 7'h01);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
      wait_ready();
      tick();
      req_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
      check("abort_no_rsp2", 32'(rsp_valid), 32'd0);
      check("abort_err_count", 32'(err_count), 32'd0);
      for (int i = 0; i < 8; i++) do_read(3'(i), 4'h0, 2'b00);
      check("abort_err_count_end", 32'(err_count), 32'd0);

      // Randomized traffic against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         req_valid = ($urandom_range(0, 1) == 1);
         req_we    = ($urandom_range(0, 2) == 0);
         req_addr  = 3'($urandom_range(0, 7));
         req_wdata = 4'($urandom_range(0, 15));
         inj_valid = ($urandom_range(0, 11) == 0);
         inj_addr  = 3'($urandom_range(0, 7));
         inj_mask  = 7'($urandom_range(0, 127));
         if ((k % 250) == 0) scrub_en = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid = 1'b0; inj_valid = 1'b0; inj_mask = 7'd0; scrub_en = 1'b0;
      repeat (4) tick();

      // Saturation of err_count
      do_reset();
      do_write(3'd0, 4'h0);
      for (int k = 0; k < 260; k++) begin
         b  = k % 7;
         ee = (b == 0 || b == 1 || b == 3) ? 2'b10 : 2'b01;
         do_inject(3'd0, 7'(1 << b));
         do_read(3'd0, 4'h0, ee);
      end
      check("sat_err_count", 32'(err_count), 32'd255);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
